// File: rtl/cpi_sync_sequencer.sv
// cpi_sync_sequencer
// Pixel-clock frame/line sequencer producing CPI vsync/href timing from
// start/end-of-frame events and a line-ready handshake with the line buffer.
//
// Ports:
//   pixel_clk_i   pixel clock, all logic on rising edge
//   pixel_rstn_i  asynchronous active-low reset
//   sof_i, eof_i  one-cycle frame event pulses
//   line_rdy_i    a complete line is available, length on line_len_i
//   line_ack_o    one-cycle pulse, the presented line is consumed
//   rd_en_o       buffer read strobe, one pixel per cycle
//   vsync_o       CPI vertical sync, active high
//   href_o        CPI line valid, rd_en_o delayed by the buffer read latency
//   frame_busy_o  sequencer is not idle
//   err_o         one-cycle pulse on resync (sof while busy)
//
// Optional feature macro: CPI_SEQ_LINE_STATS_EN adds line_cnt_o (completed
// non-empty lines in the current frame) and frame_lines_o (line count of the
// last frame closed by eof).

module cpi_sync_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned VSYNC_CYC  = 64,
    parameter int unsigned VBP_CYC    = 128,
    parameter int unsigned HBLANK_CYC = 32
) (
    input  logic             pixel_clk_i,
    input  logic             pixel_rstn_i,
    input  logic             sof_i,
    input  logic             eof_i,
    input  logic             line_rdy_i,
    input  logic [CNT_W-1:0] line_len_i,
    output logic             line_ack_o,
    output logic             rd_en_o,
    output logic             vsync_o,
    output logic             href_o,
    output logic             frame_busy_o,
    output logic             err_o
`ifdef CPI_SEQ_LINE_STATS_EN
    ,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [CNT_W-1:0] frame_lines_o
`endif
);

    // Zero-length porches are stretched to one cycle; zero hblank skips HBLANK.
    localparam int unsigned VS_N = (VSYNC_CYC == 0) ? 1 : VSYNC_CYC;
    localparam int unsigned VB_N = (VBP_CYC == 0) ? 1 : VBP_CYC;
    localparam int unsigned HB_N = (HBLANK_CYC == 0) ? 1 : HBLANK_CYC;

    localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VS_N - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VB_N - 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic             HB_SKIP = (HBLANK_CYC == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_WAIT,
        S_LINE,
        S_HBLANK
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_last_q;
    logic             eof_pend_q;

    logic [CNT_W-1:0] cnt_inc;
    logic             line_done;
    logic             frame_done;

    // Saturating cycle counter increment.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Last pixel of an untruncated line, and an eof-driven return to idle.
    assign line_done  = !sof_i && (state_q == S_LINE) && (cnt_q == len_last_q);
    assign frame_done = !sof_i && (state_q == S_WAIT) && (eof_i || eof_pend_q);

    // Frame/line sequencer with registered outputs.
    always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
        if (!pixel_rstn_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_last_q   <= '0;
            eof_pend_q   <= 1'b0;
            line_ack_o   <= 1'b0;
            rd_en_o      <= 1'b0;
            vsync_o      <= 1'b0;
            frame_busy_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            line_ack_o <= 1'b0;
            err_o      <= 1'b0;
            if (sof_i) begin
                // New frame; when busy this is a resync that truncates the
                // current line without re-acking it and drops a pending eof.
                state_q      <= S_VSYNC;
                cnt_q        <= '0;
                eof_pend_q   <= 1'b0;
                vsync_o      <= 1'b1;
                rd_en_o      <= 1'b0;
                frame_busy_o <= 1'b1;
                err_o        <= (state_q != S_IDLE);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                    end
                    S_VSYNC: begin
                        if (eof_i) eof_pend_q <= 1'b1;
                        if (cnt_q == VS_LAST) begin
                            state_q <= S_VBP;
                            cnt_q   <= '0;
                            vsync_o <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_VBP: begin
                        if (eof_i) eof_pend_q <= 1'b1;
                        if (cnt_q == VB_LAST) begin
                            state_q <= S_WAIT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_WAIT: begin
                        if (frame_done) begin
                            state_q      <= S_IDLE;
                            eof_pend_q   <= 1'b0;
                            frame_busy_o <= 1'b0;
                        end else if (line_rdy_i && !line_ack_o) begin
                            // During the ack cycle the buffer still shows the
                            // consumed line, so it is not sampled again.
                            line_ack_o <= 1'b1;
                            if (line_len_i != '0) begin
                                state_q    <= S_LINE;
                                cnt_q      <= '0;
                                len_last_q <= line_len_i - CNT_W'(1);
                                rd_en_o    <= 1'b1;
                            end
                        end
                    end
                    S_LINE: begin
                        if (eof_i) eof_pend_q <= 1'b1;
                        if (line_done) begin
                            state_q <= HB_SKIP ? S_WAIT : S_HBLANK;
                            cnt_q   <= '0;
                            rd_en_o <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_HBLANK: begin
                        if (eof_i) eof_pend_q <= 1'b1;
                        if (cnt_q == HB_LAST) begin
                            state_q <= S_WAIT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        cnt_q        <= '0;
                        eof_pend_q   <= 1'b0;
                        rd_en_o      <= 1'b0;
                        vsync_o      <= 1'b0;
                        frame_busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // href mirrors the read strobe after the one-cycle buffer read latency.
    always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
        if (!pixel_rstn_i) begin
            href_o <= 1'b0;
        end else begin
            href_o <= rd_en_o;
        end
    end

`ifdef CPI_SEQ_LINE_STATS_EN
    // Per-frame line statistics.
    always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
        if (!pixel_rstn_i) begin
            line_cnt_o    <= '0;
            frame_lines_o <= '0;
        end else begin
            if (sof_i) begin
                line_cnt_o <= '0;
            end else if (line_done && (line_cnt_o != CNT_MAX)) begin
                line_cnt_o <= line_cnt_o + CNT_W'(1);
            end
            if (frame_done) frame_lines_o <= line_cnt_o;
        end
    end
`endif

endmodule
